// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multicycle controller: opcodes, ALU/PC-source encodings, FSM states.
// Latency: none (constants only). Backpressure: n/a.
// States are plain 4-bit localparams so older netlists that compare raw state codes keep working.
package multicycle_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_MEM_ADDR = 4'd3;
    localparam logic [3:0] S_MEM_RD   = 4'd4;
    localparam logic [3:0] S_MEM_WB   = 4'd5;
    localparam logic [3:0] S_MEM_WR   = 4'd6;
    localparam logic [3:0] S_R_EXEC   = 4'd7;
    localparam logic [3:0] S_R_WB     = 4'd8;
    localparam logic [3:0] S_I_EXEC   = 4'd9;
    localparam logic [3:0] S_I_WB     = 4'd10;
    localparam logic [3:0] S_BRANCH   = 4'd11;
    localparam logic [3:0] S_JUMP     = 4'd12;
    localparam logic [3:0] S_TRAP     = 4'd13;

endpackage

// File: rtl/multicycle_control_if.sv
// Datapath <-> controller bundle: master = control unit, slave = datapath/memory side.
// Latency: wires only. Backpressure: mem_ready stalls the controller in memory phases.
interface multicycle_control_if #(parameter int CNT_W = 32);

    logic [5:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             mem_req;
    logic             PCWrite;
    logic             PCWriteCond;
    logic             IRWrite;
    logic [1:0]       PCSrc;
    logic             branch;
    logic             MemRead;
    logic             MemToWrite;
    logic             MemToReg;
    logic             ALUSrc;
    logic             RegDst;
    logic             RegWrite;
    logic [2:0]       ALUOp;
    logic [CNT_W-1:0] instr_count;
    logic             illegal_op;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, PCWrite, PCWriteCond, IRWrite, PCSrc, branch, MemRead,
               MemToWrite, MemToReg, ALUSrc, RegDst, RegWrite, ALUOp, instr_count, illegal_op
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, PCWrite, PCWriteCond, IRWrite, PCSrc, branch, MemRead,
               MemToWrite, MemToReg, ALUSrc, RegDst, RegWrite, ALUOp, instr_count, illegal_op
    );

endinterface

// File: rtl/multicycle_control.sv
// Moore multicycle controller: FETCH/DECODE/EXEC/MEM/WB sequencing plus retired-instruction counter; ILLEGAL_TRAP_EN adds a TRAP state.
// Latency: 3 cycles J/BEQ, 4 RTYPE/ADDI/SW, 5 LW with mem_ready held high.
// Backpressure: FETCH, MEM_RD and MEM_WR hold one extra cycle per mem_ready=0 cycle.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);

    logic [3:0]       state;
    logic [3:0]       nextState;
    logic [CNT_W-1:0] instrCount;
    logic             retire;

    always_comb begin
        nextState = state;
        case (state)
            S_IDLE:     nextState = S_FETCH;
            S_FETCH:    if (bus.mem_ready) nextState = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: nextState = S_MEM_ADDR;
                    OP_RTYPE:     nextState = S_R_EXEC;
                    OP_ADDI:      nextState = S_I_EXEC;
                    OP_BEQ:       nextState = S_BRANCH;
                    OP_J:         nextState = S_JUMP;
`ifdef ILLEGAL_TRAP_EN
                    default:      nextState = S_TRAP;
`else
                    default:      nextState = S_FETCH;
`endif
                endcase
            end
            S_MEM_ADDR: nextState = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (bus.mem_ready) nextState = S_MEM_WB;
            S_MEM_WR:   if (bus.mem_ready) nextState = S_FETCH;
            S_R_EXEC:   nextState = S_R_WB;
            S_I_EXEC:   nextState = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: nextState = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:     nextState = S_TRAP;
`endif
            default:    nextState = S_IDLE;
        endcase
    end

    // Every return to FETCH except the IDLE start and a FETCH stall retires one instruction (NOPs included).
    assign retire = (nextState == S_FETCH) && (state != S_FETCH) && (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            instrCount <= '0;
        end else begin
            state <= nextState;
            if (retire) instrCount <= instrCount + 1'b1;
        end
    end

    always_comb begin
        bus.mem_req     = 1'b0;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.PCSrc       = PCSRC_ALU;
        bus.branch      = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemToWrite  = 1'b0;
        bus.MemToReg    = 1'b0;
        bus.ALUSrc      = 1'b0;
        bus.RegDst      = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUOp       = ALU_ADD;
        case (state)
            S_FETCH: begin
                bus.mem_req = 1'b1;
                bus.MemRead = 1'b1;
                // PC/IR commit only in the cycle the fetched word actually arrives.
                bus.IRWrite = bus.mem_ready;
                bus.PCWrite = bus.mem_ready;
            end
            S_MEM_ADDR: bus.ALUSrc = 1'b1;
            S_MEM_RD: begin
                bus.mem_req = 1'b1;
                bus.MemRead = 1'b1;
            end
            S_MEM_WB: begin
                bus.RegWrite = 1'b1;
                bus.MemToReg = 1'b1;
            end
            S_MEM_WR: begin
                bus.mem_req    = 1'b1;
                bus.MemToWrite = 1'b1;
            end
            S_R_EXEC:   bus.ALUOp = ALU_FUNCT;
            S_R_WB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
            end
            S_I_EXEC:   bus.ALUSrc = 1'b1;
            S_I_WB:     bus.RegWrite = 1'b1;
            S_BRANCH: begin
                bus.branch      = 1'b1;
                bus.PCWriteCond = 1'b1;
                bus.ALUOp       = ALU_SUB;
                bus.PCSrc       = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                bus.PCWrite = 1'b1;
                bus.PCSrc   = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    assign bus.illegal_op = (state == S_TRAP);
`else
    assign bus.illegal_op = 1'b0;
`endif

    assign bus.instr_count = instrCount;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle vector table through a scoreboard queue, plus a reset-abort sequence.
// A 3-bit counter makes the modulo wrap reachable.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_control_if #(.CNT_W(CW)) bus();
    multicycle_control #(.CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic       memReq;
        logic       pcWrite;
        logic       pcWriteCond;
        logic       irWrite;
        logic [1:0] pcSrc;
        logic       branch;
        logic       memRead;
        logic       memToWrite;
        logic       memToReg;
        logic       aluSrc;
        logic       regDst;
        logic       regWrite;
        logic [2:0] aluOp;
        logic       illegal;
    } ctl_t;

    localparam ctl_t E_ZERO  = '0;
    localparam ctl_t E_FRDY  = '{memReq: 1'b1, pcWrite: 1'b1, irWrite: 1'b1, memRead: 1'b1, default: '0};
    localparam ctl_t E_FWAIT = '{memReq: 1'b1, memRead: 1'b1, default: '0};
    localparam ctl_t E_MADDR = '{aluSrc: 1'b1, default: '0};
    localparam ctl_t E_MRD   = '{memReq: 1'b1, memRead: 1'b1, default: '0};
    localparam ctl_t E_MWB   = '{regWrite: 1'b1, memToReg: 1'b1, default: '0};
    localparam ctl_t E_MWR   = '{memReq: 1'b1, memToWrite: 1'b1, default: '0};
    localparam ctl_t E_REXEC = '{aluOp: 3'b010, default: '0};
    localparam ctl_t E_RWB   = '{regWrite: 1'b1, regDst: 1'b1, default: '0};
    localparam ctl_t E_IEXEC = '{aluSrc: 1'b1, default: '0};
    localparam ctl_t E_IWB   = '{regWrite: 1'b1, default: '0};
    localparam ctl_t E_BR    = '{branch: 1'b1, pcWriteCond: 1'b1, aluOp: 3'b001, pcSrc: 2'b01, default: '0};
    localparam ctl_t E_JMP   = '{pcWrite: 1'b1, pcSrc: 2'b10, default: '0};
    localparam ctl_t E_TRAP  = '{illegal: 1'b1, default: '0};

    typedef struct {
        logic          r;
        logic [5:0]    op;
        logic          z;
        logic          rdy;
        ctl_t          exp;
        logic [CW-1:0] cnt;
    } vec_t;

    typedef struct {
        ctl_t          exp;
        logic [CW-1:0] cnt;
        int            idx;
    } sb_t;

    vec_t vecs[$];
    sb_t  sbQ[$];
    int   errors = 0;
    int   checks = 0;

    function ctl_t getCtl();
        getCtl = {bus.mem_req, bus.PCWrite, bus.PCWriteCond, bus.IRWrite, bus.PCSrc, bus.branch,
                  bus.MemRead, bus.MemToWrite, bus.MemToReg, bus.ALUSrc, bus.RegDst, bus.RegWrite,
                  bus.ALUOp, bus.illegal_op};
    endfunction

    task automatic check(input string name, input int idx, input ctl_t exp, input logic [CW-1:0] cnt);
        ctl_t got;
        got = getCtl();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] controls: got %h want %h", name, idx, got, exp);
        end
        checks++;
        if (bus.instr_count !== cnt) begin
            errors++;
            $display("FAIL %s[%0d] instr_count: got %0d want %0d", name, idx, bus.instr_count, cnt);
        end
    endtask

    task automatic add(input logic r, input logic [5:0] op, input logic z, input logic rdy,
                       input ctl_t e, input int cnt);
        vec_t v;
        v.r   = r;
        v.op  = op;
        v.z   = z;
        v.rdy = rdy;
        v.exp = e;
        v.cnt = cnt[CW-1:0];
        vecs.push_back(v);
    endtask

    // Outputs are compared at the falling edge, half a cycle after inputs settle.
    always @(negedge clk) begin
        sb_t s;
        if (sbQ.size() > 0) begin
            s = sbQ.pop_front();
            check("vec", s.idx, s.exp, s.cnt);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic found;
        sb_t  s;

        rst           = 1'b1;
        bus.opcode    = OP_RTYPE;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;

        for (int i = 0; i < 3; i++) add(1, OP_RTYPE, 0, 1, E_ZERO, 0);
        add(0, OP_RTYPE, 0, 1, E_ZERO, 0);                       // IDLE
        add(0, OP_RTYPE, 0, 1, E_FRDY, 0);                       // RTYPE
        add(0, OP_RTYPE, 0, 1, E_ZERO, 0);
        add(0, OP_RTYPE, 0, 1, E_REXEC, 0);
        add(0, OP_RTYPE, 0, 1, E_RWB, 0);
        add(0, OP_ADDI, 0, 1, E_FRDY, 1);                        // ADDI
        add(0, OP_ADDI, 0, 1, E_ZERO, 1);
        add(0, OP_ADDI, 0, 1, E_IEXEC, 1);
        add(0, OP_ADDI, 0, 1, E_IWB, 1);
        add(0, OP_LW, 0, 1, E_FRDY, 2);                          // LW, 3 wait cycles in MEM_RD
        add(0, OP_LW, 0, 1, E_ZERO, 2);
        add(0, OP_LW, 0, 1, E_MADDR, 2);
        for (int i = 0; i < 3; i++) add(0, OP_LW, 0, 0, E_MRD, 2);
        add(0, OP_LW, 0, 1, E_MRD, 2);
        add(0, OP_LW, 0, 1, E_MWB, 2);
        add(0, OP_SW, 0, 0, E_FWAIT, 3);                         // SW, 1 wait cycle in FETCH
        add(0, OP_SW, 0, 1, E_FRDY, 3);
        add(0, OP_SW, 0, 1, E_ZERO, 3);
        add(0, OP_SW, 0, 1, E_MADDR, 3);
        add(0, OP_SW, 0, 1, E_MWR, 3);
        add(0, OP_BEQ, 1, 1, E_FRDY, 4);                         // BEQ taken, mem_ready ignored
        add(0, OP_BEQ, 1, 1, E_ZERO, 4);
        add(0, OP_BEQ, 1, 0, E_BR, 4);
        add(0, OP_BEQ, 0, 1, E_FRDY, 5);                         // BEQ not taken
        add(0, OP_BEQ, 0, 0, E_ZERO, 5);
        add(0, OP_BEQ, 0, 1, E_BR, 5);
        add(0, OP_J, 0, 1, E_FRDY, 6);                           // J
        add(0, OP_J, 0, 0, E_ZERO, 6);
        add(0, OP_J, 0, 1, E_JMP, 6);
        add(0, 6'b111111, 0, 1, E_FRDY, 7);                      // illegal opcode
        add(0, 6'b111111, 0, 1, E_ZERO, 7);
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) add(0, 6'b111111, 0, i % 2, E_TRAP, 7);
`else
        add(0, OP_RTYPE, 0, 1, E_FRDY, 8);                       // NOP counted, 3-bit wrap to 0
        add(0, OP_RTYPE, 0, 1, E_ZERO, 8);
`endif

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            rst           = vecs[i].r;
            bus.opcode    = vecs[i].op;
            bus.zero      = vecs[i].z;
            bus.mem_ready = vecs[i].rdy;
            s.exp = vecs[i].exp;
            s.cnt = vecs[i].cnt;
            s.idx = i;
            sbQ.push_back(s);
        end
        @(negedge clk);
        #1;

        // Reset abort during a stalled MEM_WR, after one J has retired.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.opcode    = OP_J;
        bus.mem_ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk);
            #1;
            if (bus.PCSrc == 2'b10) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_jump: got no JUMP within 20 cycles want JUMP");
        end
        @(posedge clk);
        #1;
        bus.opcode = OP_SW;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk);
            #1;
            if (bus.MemToWrite) found = 1'b1;
        end
        bus.mem_ready = 1'b0;
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_memwr: got no MEM_WR within 20 cycles want MEM_WR");
        end
        #1;
        check("mwr_stall", 0, E_MWR, 1);
        @(posedge clk);
        #1;
        check("mwr_stall", 1, E_MWR, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_async", 0, E_ZERO, 0);
        @(posedge clk);
        #1;
        check("rst_held", 0, E_ZERO, 0);
        rst           = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        check("restart_idle", 0, E_ZERO, 0);
        @(posedge clk);
        #1;
        check("restart_fetch", 0, E_FRDY, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
